// File: rtl/register_file_gen.sv
// register_file_gen: parametrised CPU register file.
// NUM_PAIRS 8-bit pairs (WZ, BC, DE, HL, ...) plus full-width SP and PC.
// Features: dual 8-bit read, one 16-bit read/write, a registered
// inc/dec unit (IDU) on any 16-bit register, PC increment and masked flags.
// All reads are combinational from registered state, with no write bypass.
// Optional: define SHADOW_BANK_EN for a second bank of pairs and flags.
// The i_Swap input toggles the active bank.

// Next-value logic for one 16-bit register.
// Priority is Wr16 > IDU > PC_Inc > Wr8.
module register_file_gen_slot #(
  parameter int DATA_W = 8,
  localparam int PAIR_W = 2*DATA_W
)(
  input  logic [PAIR_W-1:0] cur,
  input  logic              wr16_hit,
  input  logic [PAIR_W-1:0] wr16_data,
  input  logic              idu_inc,
  input  logic              idu_dec,
  input  logic              pc_inc,
  input  logic              wr8_hi,
  input  logic              wr8_lo,
  input  logic [DATA_W-1:0] wr8_data,
  output logic [PAIR_W-1:0] nxt
);
  localparam logic [PAIR_W-1:0] ONE = PAIR_W'(1);

  // The highest-priority source wins. The losing sources are discarded.
  always_comb begin
    nxt = cur;
    if (wr16_hit)     nxt = wr16_data;
    else if (idu_inc) nxt = cur + ONE;
    else if (idu_dec) nxt = cur - ONE;
    else if (pc_inc)  nxt = cur + ONE;
    else begin
      if (wr8_hi) nxt[PAIR_W-1:DATA_W] = wr8_data;
      if (wr8_lo) nxt[DATA_W-1:0]      = wr8_data;
    end
  end
endmodule

module register_file_gen #(
  parameter int          DATA_W    = 8,
  parameter int          NUM_PAIRS = 4,
  parameter logic [15:0] RESET_SP  = 16'hFFFE,
  parameter logic [15:0] RESET_PC  = 16'h0000,
  localparam int PAIR_W = 2*DATA_W,
  localparam int I8_W   = $clog2(2*NUM_PAIRS),
  localparam int I16_W  = $clog2(NUM_PAIRS+2)
)(
  input  logic              i_Clk,
  input  logic              i_nRst,
  input  logic              i_Enable,
  input  logic [I8_W-1:0]   i_RdA8_Idx,
  input  logic [I8_W-1:0]   i_RdB8_Idx,
  output logic [DATA_W-1:0] o_RdA8,
  output logic [DATA_W-1:0] o_RdB8,
  input  logic              i_Wr8_En,
  input  logic [I8_W-1:0]   i_Wr8_Idx,
  input  logic [DATA_W-1:0] i_Wr8_Data,
  input  logic [I16_W-1:0]  i_Rd16_Idx,
  output logic [PAIR_W-1:0] o_Rd16,
  input  logic              i_Wr16_En,
  input  logic [I16_W-1:0]  i_Wr16_Idx,
  input  logic [PAIR_W-1:0] i_Wr16_Data,
  input  logic [1:0]        i_IDU_Op,
  input  logic [I16_W-1:0]  i_IDU_Idx,
  output logic [PAIR_W-1:0] o_IDU_Pre,
  input  logic              i_PC_Inc,
  input  logic [3:0]        i_F_Wr_Mask,
  input  logic [3:0]        i_F_Data,
  output logic [7:0]        o_F,
  output logic [PAIR_W-1:0] o_PC,
  output logic [PAIR_W-1:0] o_SP,
  output logic [PAIR_W-1:0] o_HL
`ifdef SHADOW_BANK_EN
  ,
  input  logic              i_Swap
`endif
);
  // 16-bit index space: the pairs come first, then SP, then PC.
  localparam int NWIDE = NUM_PAIRS + 2;
  localparam int SP_K  = NUM_PAIRS;
  localparam int PC_K  = NUM_PAIRS + 1;
  localparam int HL_K  = (NUM_PAIRS > 3) ? 3 : NUM_PAIRS - 1;

  logic [NUM_PAIRS-1:0][PAIR_W-1:0] act;
  logic [3:0]                       flags;
  logic [3:0]                       flags_nxt;
  logic [PAIR_W-1:0]                sp_q, pc_q;
  logic [NWIDE-1:0][PAIR_W-1:0]     wide, nxt;
  logic                             idu_inc, idu_dec;

  // Op code 11 is reserved and behaves the same as no operation.
  assign idu_inc   = (i_IDU_Op == 2'b01);
  assign idu_dec   = (i_IDU_Op == 2'b10);
  assign flags_nxt = (flags & ~i_F_Wr_Mask) | (i_F_Data & i_F_Wr_Mask);

  // Flat view of every 16-bit register. Read muxes and slots index into it.
  always_comb begin
    wide = '0;
    for (int p = 0; p < NUM_PAIRS; p++) wide[p] = act[p];
    wide[SP_K] = sp_q;
    wide[PC_K] = pc_q;
  end

  for (genvar k = 0; k < NWIDE; k++) begin : g_slot
    register_file_gen_slot #(.DATA_W(DATA_W)) u_slot (
      .cur       (wide[k]),
      .wr16_hit  (i_Wr16_En && (int'(i_Wr16_Idx) == k)),
      .wr16_data (i_Wr16_Data),
      .idu_inc   (idu_inc && (int'(i_IDU_Idx) == k)),
      .idu_dec   (idu_dec && (int'(i_IDU_Idx) == k)),
      .pc_inc    (i_PC_Inc && (k == PC_K)),
      .wr8_hi    ((k < NUM_PAIRS) && i_Wr8_En && (int'(i_Wr8_Idx) == 2*k)),
      .wr8_lo    ((k < NUM_PAIRS) && i_Wr8_En && (int'(i_Wr8_Idx) == 2*k+1)),
      .wr8_data  (i_Wr8_Data),
      .nxt       (nxt[k])
    );
  end

`ifdef SHADOW_BANK_EN
  logic [1:0][NUM_PAIRS-1:0][PAIR_W-1:0] bank_q;
  logic [1:0][3:0]                       flag_q;
  logic                                  bank_sel;

  assign act   = bank_q[bank_sel];
  assign flags = flag_q[bank_sel];

  // Updates land in the bank that was active before the edge.
  // A swap on the same edge only redirects later accesses.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      bank_q   <= '0;
      flag_q   <= '0;
      bank_sel <= 1'b0;
    end else if (i_Enable) begin
      for (int p = 0; p < NUM_PAIRS; p++) bank_q[bank_sel][p] <= nxt[p];
      flag_q[bank_sel] <= flags_nxt;
      if (i_Swap) bank_sel <= ~bank_sel;
    end
  end
`else
  logic [NUM_PAIRS-1:0][PAIR_W-1:0] pair_q;
  logic [3:0]                       flag_q;

  assign act   = pair_q;
  assign flags = flag_q;

  // Single bank of pairs and flags.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      pair_q <= '0;
      flag_q <= '0;
    end else if (i_Enable) begin
      for (int p = 0; p < NUM_PAIRS; p++) pair_q[p] <= nxt[p];
      flag_q <= flags_nxt;
    end
  end
`endif

  // SP and PC are never shadowed.
  always_ff @(posedge i_Clk or negedge i_nRst) begin
    if (!i_nRst) begin
      sp_q <= PAIR_W'(RESET_SP);
      pc_q <= PAIR_W'(RESET_PC);
    end else if (i_Enable) begin
      sp_q <= nxt[SP_K];
      pc_q <= nxt[PC_K];
    end
  end

  // 8-bit reads: even index is the high half, odd index is the low half.
  // An index out of range reads as 0.
  always_comb begin
    o_RdA8 = '0;
    o_RdB8 = '0;
    for (int p = 0; p < NUM_PAIRS; p++) begin
      if (int'(i_RdA8_Idx) == 2*p)   o_RdA8 = act[p][PAIR_W-1:DATA_W];
      if (int'(i_RdA8_Idx) == 2*p+1) o_RdA8 = act[p][DATA_W-1:0];
      if (int'(i_RdB8_Idx) == 2*p)   o_RdB8 = act[p][PAIR_W-1:DATA_W];
      if (int'(i_RdB8_Idx) == 2*p+1) o_RdB8 = act[p][DATA_W-1:0];
    end
  end

  // 16-bit read and IDU pre-update tap. An index out of range reads as 0.
  always_comb begin
    o_Rd16    = '0;
    o_IDU_Pre = '0;
    for (int k = 0; k < NWIDE; k++) begin
      if (int'(i_Rd16_Idx) == k) o_Rd16    = wide[k];
      if (int'(i_IDU_Idx)  == k) o_IDU_Pre = wide[k];
    end
  end

  assign o_F  = {flags, 4'b0000};
  assign o_PC = pc_q;
  assign o_SP = sp_q;
  assign o_HL = act[HL_K];
endmodule

// File: tb/tb_register_file_gen.sv
// Self-checking bench for register_file_gen. Expected values are queued
// when stimulus is driven and popped when the DUT output is sampled.
// SHADOW_BANK_EN adds the bank-swap scenario.
module tb_register_file_gen;
  logic        clk = 0, rst_n = 0, en;
  logic [2:0]  rda_idx, rdb_idx, wr8_idx, rd16_idx, wr16_idx, idu_idx;
  logic [7:0]  rda, rdb, wr8_data, f;
  logic        wr8_en, wr16_en, pc_inc;
  logic [15:0] rd16, wr16_data, idu_pre, pc, sp, hl;
  logic [1:0]  idu_op;
  logic [3:0]  f_mask, f_data;
`ifdef SHADOW_BANK_EN
  logic        swap;
`endif

  int vectors = 0, miscompares = 0;
  logic [15:0] exp_q[$];
  logic [15:0] got, want;

  register_file_gen dut (
    .i_Clk(clk), .i_nRst(rst_n), .i_Enable(en),
    .i_RdA8_Idx(rda_idx), .i_RdB8_Idx(rdb_idx), .o_RdA8(rda), .o_RdB8(rdb),
    .i_Wr8_En(wr8_en), .i_Wr8_Idx(wr8_idx), .i_Wr8_Data(wr8_data),
    .i_Rd16_Idx(rd16_idx), .o_Rd16(rd16),
    .i_Wr16_En(wr16_en), .i_Wr16_Idx(wr16_idx), .i_Wr16_Data(wr16_data),
    .i_IDU_Op(idu_op), .i_IDU_Idx(idu_idx), .o_IDU_Pre(idu_pre),
    .i_PC_Inc(pc_inc), .i_F_Wr_Mask(f_mask), .i_F_Data(f_data), .o_F(f),
    .o_PC(pc), .o_SP(sp), .o_HL(hl)
`ifdef SHADOW_BANK_EN
    , .i_Swap(swap)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle();
    en = 1; wr8_en = 0; wr16_en = 0; pc_inc = 0; idu_op = 2'b00;
    f_mask = 4'h0; f_data = 4'h0; wr8_idx = 0; wr8_data = 0;
    wr16_idx = 0; wr16_data = 0; idu_idx = 0;
`ifdef SHADOW_BANK_EN
    swap = 0;
`endif
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle(); rst_n = 0; rda_idx = 0; rdb_idx = 0; rd16_idx = 0;
    // Strobes driven during reset must be ignored.
    wr16_en = 1; wr16_idx = 3'd5; wr16_data = 16'h5A5A; pc_inc = 1;
    step(); step();
    rd16_idx = 3'd4; exp_q.push_back(16'hFFFE); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_sp got %h want %h", got, want); end
    rd16_idx = 3'd5; exp_q.push_back(16'h0000); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_pc got %h want %h", got, want); end
    for (int i = 0; i < 8; i++) begin
      rda_idx = 3'(i); exp_q.push_back(16'h0000); #1;
      got = {8'h00, rda}; want = exp_q.pop_front(); vectors++;
      if (got !== want) begin miscompares++; $display("FAIL reset_r8[%0d] got %h want %h", i, got, want); end
    end
    exp_q.push_back(16'h0000);
    got = {8'h00, f}; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_f got %h want %h", got, want); end
    idle(); #2 rst_n = 1; step();
  endtask

  task automatic test_wr8();
    wr8_en = 1; wr8_idx = 3'd6; wr8_data = 8'h12; rda_idx = 3'd6;
    // Without a bypass, the register still shows its old value before the edge.
    exp_q.push_back(16'h0000); #1;
    got = {8'h00, rda}; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL wr8_no_bypass got %h want %h", got, want); end
    step();
    wr8_idx = 3'd7; wr8_data = 8'h34; step(); idle();
    rd16_idx = 3'd3; rda_idx = 3'd7; rdb_idx = 3'd6;
    exp_q.push_back(16'h1234); exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0034); exp_q.push_back(16'h0012); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL wr8_rd16_hl got %h want %h", got, want); end
    got = hl; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL wr8_o_hl got %h want %h", got, want); end
    got = {8'h00, rda}; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL wr8_rda_l got %h want %h", got, want); end
    got = {8'h00, rdb}; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL wr8_rdb_h got %h want %h", got, want); end
  endtask

  task automatic test_idu();
    wr16_en = 1; wr16_idx = 3'd1; wr16_data = 16'hFFFF; step(); idle();
    idu_op = 2'b01; idu_idx = 3'd1; exp_q.push_back(16'hFFFF); #1;
    got = idu_pre; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL idu_pre got %h want %h", got, want); end
    step(); idle(); rd16_idx = 3'd1; exp_q.push_back(16'h0000); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL idu_inc_wrap got %h want %h", got, want); end
    idu_op = 2'b10; idu_idx = 3'd1; step(); idle(); exp_q.push_back(16'hFFFF); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL idu_dec_wrap got %h want %h", got, want); end
    idu_op = 2'b11; idu_idx = 3'd1; step(); idle(); exp_q.push_back(16'hFFFF); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL idu_reserved got %h want %h", got, want); end
  endtask

  task automatic test_priority();
    wr16_en = 1; wr16_idx = 3'd2; wr16_data = 16'hAAAA;
    idu_op = 2'b01; idu_idx = 3'd2; wr8_en = 1; wr8_idx = 3'd4; wr8_data = 8'h55;
    step(); idle(); rd16_idx = 3'd2; exp_q.push_back(16'hAAAA); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL prio_de got %h want %h", got, want); end
    // Wr8 and the IDU on different registers both take effect.
    wr8_en = 1; wr8_idx = 3'd0; wr8_data = 8'h77; idu_op = 2'b01; idu_idx = 3'd4;
    step(); idle(); rd16_idx = 3'd0; exp_q.push_back(16'h7700); exp_q.push_back(16'hFFFF); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL prio_wr8_wz got %h want %h", got, want); end
    got = sp; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL prio_idu_sp got %h want %h", got, want); end
    wr16_en = 1; wr16_idx = 3'd5; wr16_data = 16'h0100; step(); idle();
    idu_op = 2'b01; idu_idx = 3'd5; pc_inc = 1; step(); idle();
    exp_q.push_back(16'h0101); #1;
    got = pc; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL prio_pc_single_inc got %h want %h", got, want); end
    idu_op = 2'b10; idu_idx = 3'd5; pc_inc = 1; step(); idle();
    exp_q.push_back(16'h0100); #1;
    got = pc; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL prio_pc_idu_dec got %h want %h", got, want); end
    pc_inc = 1; step(); idle(); exp_q.push_back(16'h0101); #1;
    got = pc; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL pc_inc got %h want %h", got, want); end
  endtask

  task automatic test_flags_enable();
    f_mask = 4'b1010; f_data = 4'b1111; step();
    f_mask = 4'b0101; f_data = 4'b0000; step(); idle();
    exp_q.push_back(16'h00A0); #1;
    got = {8'h00, f}; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL flags_mask got %h want %h", got, want); end
    en = 0; wr16_en = 1; wr16_idx = 3'd3; wr16_data = 16'hDEAD; wr8_en = 1; wr8_idx = 3'd7;
    wr8_data = 8'hEE; f_mask = 4'hF; f_data = 4'h5; pc_inc = 1; idu_op = 2'b01; idu_idx = 3'd4;
    step(); step(); idle();
    exp_q.push_back(16'h1234); exp_q.push_back(16'h00A0);
    exp_q.push_back(16'h0101); exp_q.push_back(16'hFFFF); #1;
    got = hl; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL en0_hl got %h want %h", got, want); end
    got = {8'h00, f}; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL en0_f got %h want %h", got, want); end
    got = pc; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL en0_pc got %h want %h", got, want); end
    got = sp; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL en0_sp got %h want %h", got, want); end
  endtask

  task automatic test_out_of_range();
    wr16_en = 1; wr16_idx = 3'd7; wr16_data = 16'h5555; step(); idle();
    rd16_idx = 3'd7; idu_idx = 3'd6;
    exp_q.push_back(16'h0000); exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0101); exp_q.push_back(16'hFFFF); #1;
    got = rd16; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL oor_rd16 got %h want %h", got, want); end
    got = idu_pre; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL oor_idu_pre got %h want %h", got, want); end
    got = pc; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL oor_pc got %h want %h", got, want); end
    got = sp; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL oor_sp got %h want %h", got, want); end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 0; #1;
    exp_q.push_back(16'h0000); exp_q.push_back(16'hFFFE);
    got = hl; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL async_rst_hl got %h want %h", got, want); end
    got = sp; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL async_rst_sp got %h want %h", got, want); end
    idle(); #3 rst_n = 1; step();
  endtask

`ifdef SHADOW_BANK_EN
  task automatic test_shadow();
    wr16_en = 1; wr16_idx = 3'd3; wr16_data = 16'h1111; step(); idle();
    swap = 1; step(); idle(); exp_q.push_back(16'h0000); #1;
    got = hl; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL shadow_swap1 got %h want %h", got, want); end
    // A write on the swap edge lands in the bank that was active before the swap.
    wr16_en = 1; wr16_idx = 3'd3; wr16_data = 16'h2222; swap = 1; step(); idle();
    exp_q.push_back(16'h1111); #1;
    got = hl; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL shadow_swap2 got %h want %h", got, want); end
    swap = 1; step(); idle(); exp_q.push_back(16'h2222); exp_q.push_back(16'hFFFE); #1;
    got = hl; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL shadow_swap3 got %h want %h", got, want); end
    got = sp; want = exp_q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL shadow_sp got %h want %h", got, want); end
  endtask
`endif

  initial begin
    test_reset();
    test_wr8();
    test_idu();
    test_priority();
    test_flags_enable();
    test_out_of_range();
    test_async_reset();
`ifdef SHADOW_BANK_EN
    test_shadow();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
